// File: rtl/decoder_138_led_if.sv
// Signal bundle between the board switches/enables and the LED bank.
//   enable : 3-bit enable group, bit2=G1 (active-high), bit1=G2A, bit0=G2B (active-low)
//   switch : 3-bit binary select A2..A0
//   led    : 8-bit registered decoded output, bit n <-> switch==n
// master drives enable/switch and observes led; slave is the decoder.
interface decoder_138_led_if;
  logic [2:0] enable;
  logic [2:0] switch;
  logic [7:0] led;

  modport master (
    output enable,
    output switch,
    input  led
  );

  modport slave (
    input  enable,
    input  switch,
    output led
  );
endinterface

// File: rtl/decoder_138_led.sv
// Registered 3-to-8 line decoder modelled on a 74x138, driving an 8-LED bank.
// When the enable group matches ENABLE_CODE exactly, the LED selected by switch is put in
// the active state and all others idle; otherwise every LED is idle. The output is a
// clocked register, so inputs reach led one rising edge later.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset; forces led to idle immediately
//   bus_io : decoder_138_led_if.slave (enable/switch in, led out)
//
// Parameters:
//   ENABLE_CODE : enable value that activates decoding (default 3'b100: G1=1, G2A=0, G2B=0)
//   ACTIVE_LOW  : 1 -> selected bit 0, idle bits 1; 0 -> selected bit 1, idle bits 0
//
// Build option:
//   DECODER_138_INPUT_SYNC_EN : when defined, enable and switch pass through a 2-flop
//   synchronizer (reset to 3'b000, an idle decode) before decoding; latency becomes 3 clocks.
module decoder_138_led #(
  parameter logic [2:0] ENABLE_CODE = 3'b100,
  parameter bit         ACTIVE_LOW  = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  decoder_138_led_if.slave        bus_io
);

  // Output value with no LED selected, in the chosen polarity.
  localparam logic [7:0] IdleVal = ACTIVE_LOW ? 8'hFF : 8'h00;

  // Values the decode is taken from (raw inputs or synchronized copies).
  logic [2:0] dec_enable;
  logic [2:0] dec_switch;

`ifdef DECODER_138_INPUT_SYNC_EN
  logic [2:0] enable_meta_q;
  logic [2:0] enable_sync_q;
  logic [2:0] switch_meta_q;
  logic [2:0] switch_sync_q;

  // Reset value 3'b000 on enable never matches a valid active code, so the decode is idle
  // until real inputs have propagated through both stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_meta_q <= 3'b000;
      enable_sync_q <= 3'b000;
      switch_meta_q <= 3'b000;
      switch_sync_q <= 3'b000;
    end else begin
      enable_meta_q <= bus_io.enable;
      enable_sync_q <= enable_meta_q;
      switch_meta_q <= bus_io.switch;
      switch_sync_q <= switch_meta_q;
    end
  end

  assign dec_enable = enable_sync_q;
  assign dec_switch = switch_sync_q;
`else
  assign dec_enable = bus_io.enable;
  assign dec_switch = bus_io.switch;
`endif

  logic       dec_hit;
  logic [7:0] sel_onehot;
  logic [7:0] led_d;
  logic [7:0] led_q;

  // Exact match on all three enable bits; every other code gives an idle output.
  assign dec_hit = (dec_enable == ENABLE_CODE);

  always_comb begin
    sel_onehot = 8'b0;
    if (dec_hit) begin
      sel_onehot = 8'b1 << dec_switch;
    end
    // Active-low: selected bit cleared from all-ones; active-high: plain one-hot.
    led_d = ACTIVE_LOW ? ~sel_onehot : sel_onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= IdleVal;
    end else begin
      led_q <= led_d;
    end
  end

  assign bus_io.led = led_q;

endmodule

// File: tb/tb_decoder_138_led.sv
module tb_decoder_138_led;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_138_led_if bus ();

  decoder_138_led dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_led;

  // Reference: 255 minus the weight of the selected bit when enable is the active code.
  function automatic logic [7:0] ref_led(input logic [2:0] e, input logic [2:0] s);
    int v;
    v = 255 - ((e == 3'd4) ? (1 << s) : 0);
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] expv);
    checks++;
    assert (bus.led === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.led, expv);
    end
  endtask

  // Advance to the next rising edge, update the model from the inputs present at that edge,
  // and compare a little after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) exp_led = 8'hFF;
    else exp_led = ref_led(bus.enable, bus.switch);
    #1;
    check(tag, exp_led);
  endtask

  initial begin
    logic [2:0] dis_codes [7];
    dis_codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    // Reset with arbitrary inputs: idle at once, before any clock edge.
    rst = 1'b1;
    bus.enable = 3'b100;
    bus.switch = 3'd6;
    #2;
    check("reset_immediate", 8'hFF);

    // Release and load the first decode.
    @(negedge clk);
    rst = 1'b0;
    bus.enable = 3'b100;
    bus.switch = 3'd0;
    step("first_decode");
    check("first_decode_const", 8'hFE);

    // Full sweep of switch with the active code.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.switch = 3'(i);
      step("sweep");
    end
    check("sweep_last", 8'h7F);

    // Every non-active enable code gives idle output.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.switch = 3'd3;
      bus.enable = dis_codes[i];
      step("disable_code");
      check("disable_idle", 8'hFF);
    end
    @(negedge clk);
    bus.enable = 3'b100;
    step("reenable");
    check("reenable_const", 8'hF7);

    // Hold between edges: a mid-cycle switch change does not reach led early.
    @(negedge clk);
    bus.switch = 3'd2;
    step("hold_pre");
    check("hold_pre_const", 8'hFB);
    #2;
    bus.switch = 3'd5;
    #1;
    check("hold_mid", 8'hFB);
    step("hold_post");
    check("hold_post_const", 8'hDF);

    // Asynchronous reset between edges, then held across an edge.
    @(negedge clk);
    bus.switch = 3'd7;
    step("pre_async");
    check("pre_async_const", 8'h7F);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 8'hFF);
    exp_led = 8'hFF;
    step("reset_across_edge");
    check("reset_held_const", 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    step("after_release");
    check("after_release_const", 8'h7F);

    // Randomized run against the reference.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.switch = 3'($urandom_range(0, 7));
      bus.enable = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
      if ($urandom_range(0, 4) == 0) begin
        rst = 1'b1;
        #1;
        check("rnd_reset", 8'hFF);
        exp_led = 8'hFF;
        #1;
        rst = 1'b0;
      end
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
